// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the control path and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivZero;

  modport master (
    output Start, Op, DataA, DataB,
    input  Busy, Done, Hi, Lo, DivZero
  );

  modport slave (
    input  Start, Op, DataA, DataB,
    output Busy, Done, Hi, Lo, DivZero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULTU/MULT/DIVU/DIV unit producing Hi/Lo,
// one shift-add or restoring-subtract step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          Reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state, state_n;
  logic [1:0]         op_q, op_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   opd_q, opd_n;
  logic               sa_q, sa_n;
  logic               sb_q, sb_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [2*WIDTH-1:0] acc_q, acc_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [WIDTH-1:0]   hi_q, hi_n;
  logic [WIDTH-1:0]   lo_q, lo_n;
  logic               dz_q, dz_n;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign sgn_a = bus.Op[0] & bus.DataA[WIDTH-1];
  assign sgn_b = bus.Op[0] & bus.DataB[WIDTH-1];
  assign mag_a = sgn_a ? -bus.DataA : bus.DataA;
  assign mag_b = sgn_b ? -bus.DataB : bus.DataB;

  // opd_q holds the multiplicand for multiply, divisor for divide
  assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
  assign trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};

  assign prod = (op_q[0] & (sa_q ^ sb_q)) ? -acc_q : acc_q;
  assign quo  = (op_q[0] & (sa_q ^ sb_q)) ?
                -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = (op_q[0] & sa_q) ?
                -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_n = state;
    op_n    = op_q;
    a_n     = a_q;
    opd_n   = opd_q;
    sa_n    = sa_q;
    sb_n    = sb_q;
    cnt_n   = cnt_q;
    acc_n   = acc_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    dz_n    = dz_q;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          op_n   = bus.Op;
          a_n    = bus.DataA;
          sa_n   = sgn_a;
          sb_n   = sgn_b;
          cnt_n  = '0;
          busy_n = 1'b1;
          if (bus.Op[1]) begin
            opd_n = mag_b;
            acc_n = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opd_n = mag_a;
            acc_n = {{WIDTH{1'b0}}, mag_b};
          end
          if (bus.Op[1] && bus.DataB == '0)
            state_n = FIX;
          else
            state_n = CALC;
        end
      end
      CALC: begin
        cnt_n = cnt_q + CW'(1);
        if (op_q[1]) begin
          if (!trial[WIDTH])
            acc_n = {trial[WIDTH-1:0],
                     acc_q[WIDTH-2:0], 1'b1};
          else
            acc_n = {acc_q[2*WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
          acc_n = {sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_n = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1))
          state_n = FIX;
      end
      FIX: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
        if (!op_q[1]) begin
          {hi_n, lo_n} = prod;
          dz_n = 1'b0;
        end else if (opd_q == '0) begin
          hi_n = a_q;
          lo_n = '1;
          dz_n = 1'b1;
        end else begin
          hi_n = rem;
          lo_n = quo;
          dz_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      opd_q  <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      a_q    <= a_n;
      opd_q  <= opd_n;
      sa_q   <= sa_n;
      sb_q   <= sb_n;
      cnt_q  <= cnt_n;
      acc_q  <= acc_n;
      busy_q <= busy_n;
      done_q <= done_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      dz_q   <= dz_n;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.DivZero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic
// reference model of MULTU/MULT/DIVU/DIV.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz,
    output int          lat
  );
    longint unsigned up;
    longint          sp;
    int              ai, bi;
    lat = 33;
    dz  = 1'b0;
    ai  = a;
    bi  = b;
    case (op)
      2'd0: begin
        up = longint'({32'h0, a}) * longint'({32'h0, b});
        {hi, lo} = up;
      end
      2'd1: begin
        sp = longint'(ai) * longint'(bi);
        {hi, lo} = sp;
      end
      default: begin
        if (b == 32'h0) begin
          lat = 1;
          dz  = 1'b1;
          hi  = a;
          lo  = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          lo = a / b;
          hi = a % b;
        end else if (a == 32'h8000_0000 &&
                     b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else begin
          lo = ai / bi;
          hi = ai % bi;
        end
      end
    endcase
  endtask

  task automatic run_op(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          disturb,
    input string       tag
  );
    logic [31:0] eh, el;
    logic        ed;
    int          lat;
    int          cyc;
    bit          seen;
    model(op, a, b, eh, el, ed, lat);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.DataA = a;
    bus.DataB = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    check({tag, " busy"}, 64'(bus.Busy), 64'd1);
    cyc  = 0;
    seen = 0;
    while (cyc < 100 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.Done) begin
        seen = 1;
      end else if (disturb) begin
        bus.DataA = $urandom;
        bus.DataB = $urandom;
        bus.Op    = 2'($urandom);
        bus.Start = (cyc % 4 == 1);
      end
    end
    bus.Start = 1'b0;
    check({tag, " lat"}, 64'(cyc), 64'(lat));
    check({tag, " busy0"}, 64'(bus.Busy), 64'd0);
    check({tag, " hi"}, 64'(bus.Hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.Lo), 64'(el));
    check({tag, " dz"}, 64'(bus.DivZero), 64'(ed));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          dcnt;
    bus.Start = 1'b0;
    bus.Op    = 2'd0;
    bus.DataA = '0;
    bus.DataB = '0;
    Reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(bus.Busy), 64'd0);
    check("rst done", 64'(bus.Done), 64'd0);
    check("rst hi", 64'(bus.Hi), 64'd0);
    check("rst lo", 64'(bus.Lo), 64'd0);
    check("rst dz", 64'(bus.DivZero), 64'd0);
    Reset = 1'b0;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    @(posedge clk);
    #1;
    check("done_pulse", 64'(bus.Done), 64'd0);
    check("hold_lo", 64'(bus.Lo), 64'h1);

    run_op(2'd1, 32'hFFFF_FFF9, 32'd3, 0, "mult_neg");
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0, "mult_min");
    run_op(2'd2, 32'd100, 32'd7, 0, "divu");
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(2'd2, 32'h1234, 32'd0, 0, "divu_zero");
    run_op(2'd0, 32'd2, 32'd3, 0, "multu_small");
    run_op(2'd3, 32'hF000_0000, 32'd0, 0, "div_zero");

    run_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1, "disturb");
    run_op(2'd3, 32'h8765_4321, 32'h0000_0123, 0, "b2b");

    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = 2'd0;
    bus.DataA = 32'hCAFE_F00D;
    bus.DataB = 32'h0BAD_BEEF;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    check("mid_rst busy", 64'(bus.Busy), 64'd0);
    check("mid_rst done", 64'(bus.Done), 64'd0);
    check("mid_rst hi", 64'(bus.Hi), 64'd0);
    check("mid_rst lo", 64'(bus.Lo), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.Done) dcnt++;
    end
    check("mid_rst nodone", 64'(dcnt), 64'd0);
    run_op(2'd2, 32'd9, 32'd3, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, a, b, (i % 5 == 0), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
